// File: rtl/irq_controller.sv
// irq_controller: 8-source priority interrupt controller with ack/eoi handshake and request timeout.
// Optional per-source mask register is built when IRQ_MASK_EN is defined.
module irq_controller #(
    parameter int TMO_CYCLES = 15
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic [7:0] irq_in,
    input  logic       int_en,
    input  logic       ack,
    input  logic       eoi,
`ifdef IRQ_MASK_EN
    input  logic       mask_wr,
    input  logic [7:0] mask_data,
`endif
    output logic       irq_req,
    output logic [2:0] irq_vec,
    output logic [7:0] pending,
    output logic       busy,
    output logic       timeout
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    localparam logic [7:0] TMO = 8'(TMO_CYCLES);

    state_t     state_q;
    logic [7:0] irq_q, pending_q, pending_d, eff, clr, cnt_q, cnt_inc;
    logic [2:0] vec_q, top;
    logic       irq_req_q, busy_q, timeout_q;

    assign cnt_inc = cnt_q + 8'd1;
    assign clr     = (state_q == REQ && ack) ? (8'd1 << vec_q) : 8'd0;

    // new rising edges win over the acknowledge clear of the same source
    assign pending_d = (pending_q & ~clr) | (irq_in & ~irq_q);

`ifdef IRQ_MASK_EN
    logic [7:0] mask_q;

    // mask register, all sources enabled out of reset
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) mask_q <= 8'hFF;
        else if (mask_wr) mask_q <= mask_data;
    end

    assign eff = pending_q & mask_q;
`else
    assign eff = pending_q;
`endif

    // highest set index of the effective request vector
    always_comb begin
        top = 3'd0;
        for (int i = 0; i < 8; i++) if (eff[i]) top = 3'(i);
    end

    // input edge history and pending latch
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            irq_q     <= 8'd0;
            pending_q <= 8'd0;
        end else begin
            irq_q     <= irq_in;
            pending_q <= pending_d;
        end
    end

    // request/service handshake FSM with registered outputs
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q   <= IDLE;
            vec_q     <= 3'd0;
            cnt_q     <= 8'd0;
            irq_req_q <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: if (int_en && eff != 8'd0) begin
                    state_q   <= REQ;
                    vec_q     <= top;
                    cnt_q     <= 8'd0;
                    irq_req_q <= 1'b1;
                end
                REQ: if (ack) begin
                    state_q   <= SERVICE;
                    irq_req_q <= 1'b0;
                    busy_q    <= 1'b1;
                end else if (!int_en) begin
                    state_q   <= IDLE;
                    irq_req_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_inc;
                    if (cnt_inc == TMO) begin
                        state_q   <= IDLE;
                        irq_req_q <= 1'b0;
                        timeout_q <= 1'b1;
                    end
                end
                SERVICE: if (eoi) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign irq_req = irq_req_q;
    assign irq_vec = vec_q;
    assign pending = pending_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: vector table, directed corner sequences and randomized run against a reference model.
module tb_irq_controller;
    localparam int TMO = 4;
    localparam int M_IDLE = 0, M_REQ = 1, M_SERV = 2;

    logic       clk = 1'b0, rstN = 1'b0, int_en = 1'b0, ack = 1'b0, eoi = 1'b0;
    logic [7:0] irq_in = 8'd0;
`ifdef IRQ_MASK_EN
    logic       mask_wr = 1'b0;
    logic [7:0] mask_data = 8'hFF;
`endif
    logic       irq_req, busy, timeout;
    logic [2:0] irq_vec;
    logic [7:0] pending;
    int         checks = 0, errors = 0;

    always #5 clk = ~clk;

    irq_controller #(.TMO_CYCLES(TMO)) dut (
        .clk(clk), .rstN(rstN), .irq_in(irq_in), .int_en(int_en), .ack(ack), .eoi(eoi),
`ifdef IRQ_MASK_EN
        .mask_wr(mask_wr), .mask_data(mask_data),
`endif
        .irq_req(irq_req), .irq_vec(irq_vec), .pending(pending), .busy(busy), .timeout(timeout)
    );

    typedef struct {
        logic [7:0] irq;
        logic       en, a, e;
        logic       req;
        logic [2:0] vec;
        logic [7:0] pend;
        logic       bsy;
    } vec_t;
    vec_t tbl[$];

    // reference model state
    logic [7:0] m_prev, m_pend, m_mask;
    int         m_mode, m_vec, m_wait;
    logic       m_to;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic r, input logic [2:0] v, input logic [7:0] p,
                           input logic b, input logic t);
        chk({tag, ".irq_req"}, 8'(irq_req), 8'(r));
        chk({tag, ".irq_vec"}, 8'(irq_vec), 8'(v));
        chk({tag, ".pending"}, pending, p);
        chk({tag, ".busy"}, 8'(busy), 8'(b));
        chk({tag, ".timeout"}, 8'(timeout), 8'(t));
    endtask

    task automatic step(input logic [7:0] irq, input logic en, input logic a, input logic e);
        irq_in = irq;
        int_en = en;
        ack = a;
        eoi = e;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_prev = 8'd0;
        m_pend = 8'd0;
        m_mask = 8'hFF;
        m_mode = M_IDLE;
        m_vec = 0;
        m_wait = 0;
        m_to = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] irq, input logic en, input logic a, input logic e,
                              input logic mw, input logic [7:0] md);
        logic [7:0] np;
        int hi;
        np = m_pend;
        m_to = 1'b0;
        if (m_mode == M_IDLE) begin
            hi = -1;
            for (int i = 0; i < 8; i++) if (m_pend[i] && m_mask[i]) hi = i;
            if (en && hi >= 0) begin
                m_mode = M_REQ;
                m_vec = hi;
                m_wait = 0;
            end
        end else if (m_mode == M_REQ) begin
            if (a) begin
                np[m_vec] = 1'b0;
                m_mode = M_SERV;
            end else if (!en) begin
                m_mode = M_IDLE;
            end else begin
                m_wait = m_wait + 1;
                if (m_wait == TMO) begin
                    m_mode = M_IDLE;
                    m_to = 1'b1;
                end
            end
        end else if (e) begin
            m_mode = M_IDLE;
        end
        for (int i = 0; i < 8; i++) if (irq[i] && !m_prev[i]) np[i] = 1'b1;
        m_pend = np;
        m_prev = irq;
        if (mw) m_mask = md;
    endtask

    initial begin
        // irq, en, ack, eoi | irq_req, irq_vec, pending, busy
        tbl.push_back('{8'h04, 1, 0, 0, 0, 3'd0, 8'h04, 0});
        tbl.push_back('{8'h00, 1, 0, 0, 1, 3'd2, 8'h04, 0});
        tbl.push_back('{8'h00, 1, 1, 0, 0, 3'd2, 8'h00, 1});
        tbl.push_back('{8'h00, 1, 0, 1, 0, 3'd2, 8'h00, 0});
        tbl.push_back('{8'h00, 1, 0, 0, 0, 3'd2, 8'h00, 0});
        tbl.push_back('{8'h42, 1, 0, 0, 0, 3'd2, 8'h42, 0});
        tbl.push_back('{8'h00, 1, 0, 0, 1, 3'd6, 8'h42, 0});
        tbl.push_back('{8'h00, 1, 1, 0, 0, 3'd6, 8'h02, 1});
        tbl.push_back('{8'h00, 1, 1, 0, 0, 3'd6, 8'h02, 1});
        tbl.push_back('{8'h00, 1, 0, 1, 0, 3'd6, 8'h02, 0});
        tbl.push_back('{8'h00, 1, 0, 0, 1, 3'd1, 8'h02, 0});
        tbl.push_back('{8'h00, 1, 1, 0, 0, 3'd1, 8'h00, 1});
        tbl.push_back('{8'h00, 1, 0, 1, 0, 3'd1, 8'h00, 0});
        tbl.push_back('{8'h00, 1, 0, 1, 0, 3'd1, 8'h00, 0});
        tbl.push_back('{8'h20, 1, 0, 0, 0, 3'd1, 8'h20, 0});
        tbl.push_back('{8'h00, 1, 0, 0, 1, 3'd5, 8'h20, 0});
        tbl.push_back('{8'h20, 1, 1, 0, 0, 3'd5, 8'h20, 1});
        tbl.push_back('{8'h00, 1, 0, 1, 0, 3'd5, 8'h20, 0});
        tbl.push_back('{8'h00, 1, 0, 0, 1, 3'd5, 8'h20, 0});
        tbl.push_back('{8'h00, 1, 1, 0, 0, 3'd5, 8'h00, 1});
        tbl.push_back('{8'h00, 1, 0, 1, 0, 3'd5, 8'h00, 0});
        tbl.push_back('{8'h01, 1, 0, 0, 0, 3'd5, 8'h01, 0});
        tbl.push_back('{8'h01, 1, 0, 0, 1, 3'd0, 8'h01, 0});
        tbl.push_back('{8'h01, 1, 1, 0, 0, 3'd0, 8'h00, 1});
        tbl.push_back('{8'h01, 1, 0, 1, 0, 3'd0, 8'h00, 0});
        tbl.push_back('{8'h00, 1, 0, 0, 0, 3'd0, 8'h00, 0});
        tbl.push_back('{8'h08, 1, 0, 0, 0, 3'd0, 8'h08, 0});
        tbl.push_back('{8'h00, 1, 0, 0, 1, 3'd3, 8'h08, 0});
        tbl.push_back('{8'h00, 0, 0, 0, 0, 3'd3, 8'h08, 0});
        tbl.push_back('{8'h00, 0, 0, 0, 0, 3'd3, 8'h08, 0});
        tbl.push_back('{8'h00, 1, 0, 0, 1, 3'd3, 8'h08, 0});
        tbl.push_back('{8'h00, 1, 1, 0, 0, 3'd3, 8'h00, 1});
        tbl.push_back('{8'h00, 1, 0, 1, 0, 3'd3, 8'h00, 0});

        #2;
        chk_out("reset", 0, 3'd0, 8'h00, 0, 0);
        @(posedge clk);
        #1;
        rstN = 1'b1;

        foreach (tbl[k]) begin
            step(tbl[k].irq, tbl[k].en, tbl[k].a, tbl[k].e);
            chk_out($sformatf("tbl%0d", k), tbl[k].req, tbl[k].vec, tbl[k].pend, tbl[k].bsy, 1'b0);
        end

        // timeout after TMO cycles in REQ, pending retained, request reissued
        step(8'h08, 1, 0, 0); chk_out("tmo.set", 0, 3'd3, 8'h08, 0, 0);
        step(8'h00, 1, 0, 0); chk_out("tmo.req", 1, 3'd3, 8'h08, 0, 0);
        for (int i = 0; i < TMO - 1; i++) begin
            step(8'h00, 1, 0, 0);
            chk_out($sformatf("tmo.wait%0d", i), 1, 3'd3, 8'h08, 0, 0);
        end
        step(8'h00, 1, 0, 0); chk_out("tmo.pulse", 0, 3'd3, 8'h08, 0, 1);
        step(8'h00, 1, 0, 0); chk_out("tmo.reissue", 1, 3'd3, 8'h08, 0, 0);
        for (int i = 0; i < TMO - 1; i++) step(8'h00, 1, 0, 0);
        step(8'h00, 1, 1, 0); chk_out("tmo.ackwins", 0, 3'd3, 8'h00, 1, 0);
        step(8'h00, 1, 0, 1); chk_out("tmo.eoi", 0, 3'd3, 8'h00, 0, 0);

        // asynchronous reset during SERVICE
        step(8'h10, 1, 0, 0);
        step(8'h00, 1, 0, 0); chk_out("rst.req", 1, 3'd4, 8'h10, 0, 0);
        step(8'h01, 1, 1, 0); chk_out("rst.serv", 0, 3'd4, 8'h01, 1, 0);
        #2;
        rstN = 1'b0;
        #1;
        chk_out("rst.async", 0, 3'd0, 8'h00, 0, 0);
        irq_in = 8'h00;
        @(posedge clk);
        #1;
        rstN = 1'b1;
        step(8'h00, 1, 1, 0); chk_out("rst.ackign", 0, 3'd0, 8'h00, 0, 0);
        step(8'h00, 1, 0, 1); chk_out("rst.eoiign", 0, 3'd0, 8'h00, 0, 0);

        // source already high when reset releases counts as an edge
        rstN = 1'b0;
        irq_in = 8'h80;
        @(posedge clk);
        #1;
        rstN = 1'b1;
        chk_out("rel.idle", 0, 3'd0, 8'h00, 0, 0);
        step(8'h80, 1, 0, 0); chk_out("rel.edge", 0, 3'd0, 8'h80, 0, 0);
        step(8'h80, 1, 0, 0); chk_out("rel.req", 1, 3'd7, 8'h80, 0, 0);
        step(8'h80, 1, 1, 0); chk_out("rel.ack", 0, 3'd7, 8'h00, 1, 0);
        step(8'h00, 1, 0, 1); chk_out("rel.eoi", 0, 3'd7, 8'h00, 0, 0);

`ifdef IRQ_MASK_EN
        mask_wr = 1'b1; mask_data = 8'h7F;
        step(8'h00, 1, 0, 0);
        mask_wr = 1'b0;
        step(8'h80, 1, 0, 0); chk_out("msk.set", 0, 3'd7, 8'h80, 0, 0);
        step(8'h80, 1, 0, 0); chk_out("msk.hold0", 0, 3'd7, 8'h80, 0, 0);
        step(8'h80, 1, 0, 0); chk_out("msk.hold1", 0, 3'd7, 8'h80, 0, 0);
        mask_wr = 1'b1; mask_data = 8'hFF;
        step(8'h80, 1, 0, 0); chk_out("msk.wr", 0, 3'd7, 8'h80, 0, 0);
        mask_wr = 1'b0;
        step(8'h80, 1, 0, 0); chk_out("msk.req", 1, 3'd7, 8'h80, 0, 0);
        step(8'h00, 1, 1, 0); chk_out("msk.ack", 0, 3'd7, 8'h00, 1, 0);
        step(8'h00, 1, 0, 1); chk_out("msk.eoi", 0, 3'd7, 8'h00, 0, 0);
`endif

        // randomized run against the reference model
        rstN = 1'b0;
        irq_in = 8'h00;
        @(posedge clk);
        #1;
        rstN = 1'b1;
        model_reset();
        for (int n = 0; n < 2000; n++) begin
            logic [7:0] irq;
            logic en, a, e, mw;
            logic [7:0] md;
            irq = irq_in;
            for (int b = 0; b < 8; b++) if ($urandom_range(0, 5) == 0) irq[b] = ~irq[b];
            en = ($urandom_range(0, 19) != 0);
            a  = ($urandom_range(0, 4) == 0);
            e  = ($urandom_range(0, 3) == 0);
            mw = 1'b0;
            md = 8'hFF;
`ifdef IRQ_MASK_EN
            mw = ($urandom_range(0, 9) == 0);
            md = 8'($urandom);
            mask_wr = mw;
            mask_data = md;
`endif
            model_step(irq, en, a, e, mw, md);
            step(irq, en, a, e);
            chk_out($sformatf("rnd%0d", n), m_mode == M_REQ, 3'(m_vec), m_pend, m_mode == M_SERV, m_to);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
